// File: rtl/sop_sweep_checker_if.sv
// sop_sweep_checker_if
//   Bundles every non-clock, non-reset signal of the sweep checker.
//   master : the checker itself (drives stimulus and results, receives start and f_in)
//   slave  : the environment (drives start and f_in, observes stimulus and results)
//
//   start            begin a sweep (ignored while busy)
//   a, b, c, d, e    registered stimulus to the SOP block; {a,b,c,d} = vector index, e = phase
//   f_in             F returned by the SOP block
//   busy, done       sweep in progress / one-cycle completion pulse
//   pass             last completed sweep had zero mismatches
//   tt_e0, tt_e1     captured truth tables for e=0 and e=1
//   err_cnt          mismatch count of the last sweep (0..32)
//   fail_idx         {phase, index} of the first mismatch
interface sop_sweep_checker_if;
  logic        start;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        e;
  logic        f_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] tt_e0;
  logic [15:0] tt_e1;
  logic [5:0]  err_cnt;
  logic [4:0]  fail_idx;

  modport master (
    input  start, f_in,
    output a, b, c, d, e, busy, done, pass, tt_e0, tt_e1, err_cnt, fail_idx
  );

  modport slave (
    output start, f_in,
    input  a, b, c, d, e, busy, done, pass, tt_e0, tt_e1, err_cnt, fail_idx
  );
endinterface

// File: rtl/sop_sweep_checker.sv
// sop_sweep_checker
//   Drives the 2x4-decoder sum-of-products block F = A(CD + B) + BC' through all
//   32 combinations of {e, a, b, c, d} (e=0 sweep first, then e=1), captures the
//   returned F into two 16-entry truth tables and checks every sample against a
//   golden expectation.
//
// Parameters
//   EXP_E0 / EXP_E1 : expected truth tables, bit i = F for {a,b,c,d} = i
//   SETTLE          : cycles each vector is held before capture (1..15)
//
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : master side of sop_sweep_checker_if (stimulus, handshake, results)
module sop_sweep_checker #(
  parameter logic [15:0] EXP_E0 = 16'h0000,
  parameter logic [15:0] EXP_E1 = 16'hF830,
  parameter int unsigned SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  sop_sweep_checker_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP0 = 2'd1,
    SWEEP1 = 2'd2
  } state_t;

  // Hold counter value on the last cycle of a vector.
  localparam logic [3:0] HOLD_LAST = 4'(SETTLE - 1);

  state_t      state_r;
  state_t      state_next_s;

  logic [3:0]  hold_r;
  logic [3:0]  idx_r;
  logic [3:0]  stim_r;
  logic        stim_e_r;
  logic        busy_r;
  logic        done_r;
  logic        pass_r;
  logic [15:0] tt_e0_r;
  logic [15:0] tt_e1_r;
  logic [5:0]  err_cnt_r;
  logic [4:0]  fail_idx_r;

  logic        capture_s;
  logic        golden_s;
  logic        mismatch_s;
  logic [5:0]  err_next_s;

  // Next-state decode plus the capture/compare strobes for the current vector.
  always_comb begin
    state_next_s = state_r;
    capture_s    = 1'b0;
    golden_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_next_s = SWEEP0;
        end else begin
          state_next_s = IDLE;
        end
      end
      SWEEP0: begin
        golden_s  = EXP_E0[idx_r];
        capture_s = (hold_r == HOLD_LAST);
        if (capture_s && (idx_r == 4'd15)) begin
          state_next_s = SWEEP1;
        end else begin
          state_next_s = SWEEP0;
        end
      end
      SWEEP1: begin
        golden_s  = EXP_E1[idx_r];
        capture_s = (hold_r == HOLD_LAST);
        if (capture_s && (idx_r == 4'd15)) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = SWEEP1;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase

    mismatch_s = capture_s && (bus.f_in != golden_s);

    // Saturating increment; 32 is the most a full sweep can produce.
    if (mismatch_s && (err_cnt_r != 6'd32)) begin
      err_next_s = err_cnt_r + 6'd1;
    end else begin
      err_next_s = err_cnt_r;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Stimulus, hold/index counters, capture and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_r     <= 4'd0;
      idx_r      <= 4'd0;
      stim_r     <= 4'd0;
      stim_e_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      tt_e0_r    <= 16'h0000;
      tt_e1_r    <= 16'h0000;
      err_cnt_r  <= 6'd0;
      fail_idx_r <= 5'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            hold_r     <= 4'd0;
            idx_r      <= 4'd0;
            stim_r     <= 4'd0;
            stim_e_r   <= 1'b0;
            busy_r     <= 1'b1;
            pass_r     <= 1'b0;
            tt_e0_r    <= 16'h0000;
            tt_e1_r    <= 16'h0000;
            err_cnt_r  <= 6'd0;
            fail_idx_r <= 5'd0;
          end
        end
        SWEEP0: begin
          if (capture_s) begin
            tt_e0_r[idx_r] <= bus.f_in;
            err_cnt_r      <= err_next_s;
            if (mismatch_s && (err_cnt_r == 6'd0)) begin
              fail_idx_r <= {1'b0, idx_r};
            end
            hold_r <= 4'd0;
            idx_r  <= idx_r + 4'd1;
            stim_r <= idx_r + 4'd1;
            // Index wraps 15 -> 0 here; the e=1 phase starts at vector 0.
            if (idx_r == 4'd15) begin
              stim_e_r <= 1'b1;
            end
          end else begin
            hold_r <= hold_r + 4'd1;
          end
        end
        SWEEP1: begin
          if (capture_s) begin
            tt_e1_r[idx_r] <= bus.f_in;
            err_cnt_r      <= err_next_s;
            if (mismatch_s && (err_cnt_r == 6'd0)) begin
              fail_idx_r <= {1'b1, idx_r};
            end
            hold_r <= 4'd0;
            idx_r  <= idx_r + 4'd1;
            stim_r <= idx_r + 4'd1;
            // Final capture: verdict uses the count including this sample.
            if (idx_r == 4'd15) begin
              stim_e_r <= 1'b0;
              busy_r   <= 1'b0;
              done_r   <= 1'b1;
              pass_r   <= (err_next_s == 6'd0);
            end
          end else begin
            hold_r <= hold_r + 4'd1;
          end
        end
        default: begin
          hold_r   <= 4'd0;
          idx_r    <= 4'd0;
          stim_r   <= 4'd0;
          stim_e_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a        = stim_r[3];
  assign bus.b        = stim_r[2];
  assign bus.c        = stim_r[1];
  assign bus.d        = stim_r[0];
  assign bus.e        = stim_e_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.pass     = pass_r;
  assign bus.tt_e0    = tt_e0_r;
  assign bus.tt_e1    = tt_e1_r;
  assign bus.err_cnt  = err_cnt_r;
  assign bus.fail_idx = fail_idx_r;

endmodule
